// File: rtl/rnd_enum.sv
// rtl/rnd_enum.sv - rounding modes and single-precision format constants
package rnd_enum;

    typedef enum logic [2:0] {
        IEEE_near = 3'd0,
        IEEE_zero = 3'd1,
        IEEE_pinf = 3'd2,
        IEEE_ninf = 3'd3,
        near_up   = 3'd4,
        away_zero = 3'd5
    } rnd_t;

    localparam int BIAS  = 127;
    localparam int SIG_W = 24;

endpackage

// File: rtl/fp_round_dec.sv
// rtl/fp_round_dec.sv - round-increment decision from sign, lsb, guard, sticky and mode
import rnd_enum::*;

module fp_round_dec (
    input  logic i_sign,
    input  logic i_lsb,
    input  logic i_guard,
    input  logic i_sticky,
    input  rnd_t i_rnd,
    output logic o_inc
);

    // Decide whether the truncated significand must be bumped by one ulp
    always_comb begin
        o_inc = 1'b0;
        case (i_rnd)
            IEEE_near: o_inc = i_guard & (i_sticky | i_lsb);
            IEEE_zero: o_inc = 1'b0;
            IEEE_pinf: o_inc = (i_guard | i_sticky) & ~i_sign;
            IEEE_ninf: o_inc = (i_guard | i_sticky) & i_sign;
            near_up:   o_inc = i_guard & (i_sticky | ~i_sign);
            away_zero: o_inc = i_guard | i_sticky;
            default:   o_inc = 1'b0;
        endcase
    end

endmodule

// File: rtl/fp_mult_seq_core.sv
// rtl/fp_mult_seq_core.sv - sequential shift-add single-precision multiplier datapath
import rnd_enum::*;

module fp_mult_seq_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  rnd_t        rnd,
    output logic        busy,
    output logic        done,
    output logic [31:0] a_q,
    output logic [31:0] b_q,
    output logic [31:0] z_calc,
    output logic        overflow,
    output logic        underflow,
    output logic        inexact
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MULT  = 2'd1,
        ST_NORM  = 2'd2,
        ST_ROUND = 2'd3
    } state_t;

    state_t                r_state;
    rnd_t                  r_rnd;
    logic [2*SIG_W-1:0]    r_mcand;
    logic [2*SIG_W-1:0]    r_acc;
    logic [SIG_W-1:0]      r_mplier;
    logic [4:0]            r_cnt;
    logic                  r_sign;
    logic [9:0]            r_exp;
    logic [SIG_W-2:0]      r_mant;
    logic                  r_g;
    logic                  r_s;

    logic                  w_inc;
    logic [SIG_W:0]        w_sig_rnd;
    logic                  w_carry;
    logic [9:0]            w_exp_fin;
    logic [SIG_W-2:0]      w_mant_fin;

    fp_round_dec u_round_dec (
        .i_sign   (r_sign),
        .i_lsb    (r_mant[0]),
        .i_guard  (r_g),
        .i_sticky (r_s),
        .i_rnd    (r_rnd),
        .o_inc    (w_inc)
    );

    // Rounded significand; a carry out of the hidden bit renormalises to 1.0 x 2^(e+1)
    always_comb begin
        w_sig_rnd  = {1'b0, 1'b1, r_mant} + {{SIG_W{1'b0}}, w_inc};
        w_carry    = w_sig_rnd[SIG_W];
        w_exp_fin  = r_exp + {9'd0, w_carry};
        w_mant_fin = w_carry ? '0 : w_sig_rnd[SIG_W-2:0];
    end

    // Control FSM with datapath registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_rnd     <= IEEE_near;
            r_mcand   <= '0;
            r_acc     <= '0;
            r_mplier  <= '0;
            r_cnt     <= '0;
            r_sign    <= 1'b0;
            r_exp     <= '0;
            r_mant    <= '0;
            r_g       <= 1'b0;
            r_s       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            z_calc    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            inexact   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        a_q      <= a;
                        b_q      <= b;
                        r_rnd    <= rnd;
                        r_sign   <= a[31] ^ b[31];
                        r_exp    <= {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'(BIAS);
                        r_mcand  <= {{SIG_W{1'b0}}, 1'b1, a[22:0]};
                        r_mplier <= {1'b1, b[22:0]};
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        busy     <= 1'b1;
                        r_state  <= ST_MULT;
                    end
                end
                ST_MULT: begin
                    if (r_mplier[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 5'd1;
                    if (r_cnt == 5'(SIG_W - 1)) begin
                        r_state <= ST_NORM;
                    end
                end
                ST_NORM: begin
                    if (r_acc[47]) begin
                        r_exp  <= r_exp + 10'd1;
                        r_mant <= r_acc[46:24];
                        r_g    <= r_acc[23];
                        r_s    <= |r_acc[22:0];
                    end else begin
                        r_mant <= r_acc[45:23];
                        r_g    <= r_acc[22];
                        r_s    <= |r_acc[21:0];
                    end
                    r_state <= ST_ROUND;
                end
                ST_ROUND: begin
                    z_calc    <= {r_sign, w_exp_fin[7:0], w_mant_fin};
                    overflow  <= $signed(w_exp_fin) >= 10'sd255;
                    underflow <= $signed(w_exp_fin) <= 10'sd0;
                    inexact   <= r_g | r_s;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
